// File: rtl/cart_bank_ctrl.sv
// Cartridge banking controller: maps the Atari S4/S5 windows onto the 512k flash for SDX, OSS, 8k and 16k images.
// Optional XEGS mode is built only when the XEGS_EN macro is defined.
module cart_bank_ctrl #(
    parameter int ROM_AW      = 19,
    parameter int SDX_BANK_W  = 4,
    parameter int OSS043_BASE = 16,
    parameter int OSS034_BASE = 18,
    parameter int CAR16_BASE  = 20,
    parameter int CAR8_BASE   = 22,
    parameter int XEGS_BASE   = 32,
    parameter int XEGS_BANKS  = 8
) (
    input  logic              phi2,
    input  logic              rst,
    input  logic [12:0]       cart_a,
    input  logic [7:0]        cart_d_in,
    input  logic              s4_n,
    input  logic              s5_n,
    input  logic              cctl_n,
    input  logic              r_w,
    input  logic [2:0]        cfg,
    output logic              rd4,
    output logic              rd5,
    output logic [ROM_AW-1:0] rom_a,
    output logic              rom_ce_n,
    output logic              rom_oe_n,
    output logic              cart_d_oe,
    output logic              led_sdx,
    output logic              led_cart
);

    localparam int unsigned BANK8K = 32'd8192;

    localparam logic [ROM_AW-1:0] OSS043_OFS = ROM_AW'(OSS043_BASE * BANK8K);
    localparam logic [ROM_AW-1:0] OSS034_OFS = ROM_AW'(OSS034_BASE * BANK8K);
    localparam logic [ROM_AW-1:0] CAR16_LO   = ROM_AW'(CAR16_BASE * BANK8K);
    localparam logic [ROM_AW-1:0] CAR16_HI   = ROM_AW'((CAR16_BASE + 32'd1) * BANK8K);
    localparam logic [ROM_AW-1:0] CAR8_OFS   = ROM_AW'(CAR8_BASE * BANK8K);

    // Reject parameter sets that cannot be mapped into the flash.
    if ((SDX_BANK_W < 32'd1) || (SDX_BANK_W > 32'd4) ||
        (XEGS_BANKS < 32'd2) || (XEGS_BANKS > 32'd16) ||
        ((XEGS_BANKS & (XEGS_BANKS - 32'd1)) != 32'd0) ||
        ((XEGS_BASE + XEGS_BANKS) * BANK8K > (32'd1 << ROM_AW))) begin : g_param_err
        $error("cart_bank_ctrl: illegal parameter set");
    end

    typedef enum logic [1:0] {
        ST_SDX  = 2'd0,
        ST_CART = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        MD_8K     = 3'd0,
        MD_16K    = 3'd1,
        MD_OSS034 = 3'd2,
        MD_OSS043 = 3'd3,
        MD_XEGS   = 3'd4
    } mode_t;

    // SDX bank is the inverted address pattern, trimmed to the configured width.
    function automatic logic [SDX_BANK_W-1:0] sdx_bank_f(input logic [3:0] a_bits);
        logic [3:0] raw_v;
        raw_v = ~a_bits;
        return raw_v[SDX_BANK_W-1:0];
    endfunction

    // OSS cartridges scramble the bank number differently for 043M and 034M.
    function automatic logic [1:0] oss_bank_f(input logic [3:0] a_low, input logic is_043);
        logic [1:0] bank_v;
        case (a_low)
            4'b0000:          bank_v = 2'd0;
            4'b0011, 4'b0111: bank_v = is_043 ? 2'd2 : 2'd1;
            4'b0100:          bank_v = is_043 ? 2'd1 : 2'd2;
            default:          bank_v = 2'd3;
        endcase
        return bank_v;
    endfunction

    state_t                state_r, state_n_s;
    mode_t                 mode_r, mode_n_s, cfg_mode_s;
    logic                  rd4_r, rd4_n_s, rd5_r, rd5_n_s;
    logic [SDX_BANK_W-1:0] sdx_bank_r, sdx_bank_n_s;
    logic [1:0]            oss_bank_r, oss_bank_n_s;
    logic                  wr_s, win_s, s4_sel_s, s5_sel_s, sel_s;
    logic [13:0]           oss_lo_s;
    logic [ROM_AW-1:0]     rom_a_s;

`ifdef XEGS_EN
    localparam int XB_W = $clog2(XEGS_BANKS);
    localparam logic [ROM_AW-1:0] XEGS_OFS  = ROM_AW'(XEGS_BASE * BANK8K);
    localparam logic [ROM_AW-1:0] XEGS_LAST = ROM_AW'((XEGS_BASE + XEGS_BANKS - 32'd1) * BANK8K);
    logic [XB_W-1:0] xegs_bank_r, xegs_bank_n_s;
`else
    logic unused_d_s;
    assign unused_d_s = ^cart_d_in;
`endif

    assign wr_s  = ~cctl_n & ~r_w;
    assign win_s = (cart_a[7:5] == 3'b111);

    // Decode the image selector into a cartridge mode.
    always_comb begin
        cfg_mode_s = MD_8K;
        case (cfg)
            3'd3:    cfg_mode_s = MD_OSS043;
            3'd2:    cfg_mode_s = MD_OSS034;
            3'd1:    cfg_mode_s = MD_16K;
`ifdef XEGS_EN
            3'd4:    cfg_mode_s = MD_XEGS;
`endif
            default: cfg_mode_s = MD_8K;
        endcase
    end

    // Next-state logic: only $D5xx write cycles change anything.
    always_comb begin
        state_n_s     = state_r;
        mode_n_s      = mode_r;
        rd4_n_s       = rd4_r;
        rd5_n_s       = rd5_r;
        sdx_bank_n_s  = sdx_bank_r;
        oss_bank_n_s  = oss_bank_r;
`ifdef XEGS_EN
        xegs_bank_n_s = xegs_bank_r;
`endif
        if (wr_s) begin
            case (state_r)
                ST_SDX: begin
                    if (win_s && !cart_a[3]) begin
                        sdx_bank_n_s = sdx_bank_f({cart_a[4], cart_a[2:0]});
                    end else if (win_s && !cart_a[2]) begin
                        state_n_s = ST_CART;
                        mode_n_s  = cfg_mode_s;
                        rd4_n_s   = (cfg_mode_s == MD_16K) || (cfg_mode_s == MD_XEGS);
                        rd5_n_s   = 1'b1;
                    end else if (win_s) begin
                        state_n_s = ST_OFF;
                        rd4_n_s   = 1'b0;
                        rd5_n_s   = 1'b0;
                    end else begin
                        state_n_s = ST_SDX;
                    end
                end
                ST_CART: begin
                    case (mode_r)
                        MD_OSS043, MD_OSS034: begin
                            if (cart_a[3]) begin
                                state_n_s = ST_OFF;
                                rd4_n_s   = 1'b0;
                                rd5_n_s   = 1'b0;
                            end else begin
                                oss_bank_n_s = oss_bank_f(cart_a[3:0], mode_r == MD_OSS043);
                            end
                        end
`ifdef XEGS_EN
                        MD_XEGS: begin
                            if (win_s && (cart_a[3:2] == 2'b11)) begin
                                state_n_s = ST_OFF;
                                rd4_n_s   = 1'b0;
                                rd5_n_s   = 1'b0;
                            end else begin
                                xegs_bank_n_s = cart_d_in[XB_W-1:0];
                            end
                        end
`endif
                        default: begin
                            if (win_s && (cart_a[3:2] == 2'b11)) begin
                                state_n_s = ST_OFF;
                                rd4_n_s   = 1'b0;
                                rd5_n_s   = 1'b0;
                            end else begin
                                state_n_s = ST_CART;
                            end
                        end
                    endcase
                end
                ST_OFF: begin
                    if (win_s && !cart_a[3]) begin
                        state_n_s     = ST_SDX;
                        rd4_n_s       = 1'b0;
                        rd5_n_s       = 1'b1;
                        sdx_bank_n_s  = sdx_bank_f({cart_a[4], cart_a[2:0]});
                        oss_bank_n_s  = 2'd0;
`ifdef XEGS_EN
                        xegs_bank_n_s = {XB_W{1'b0}};
`endif
                    end else begin
                        state_n_s = ST_OFF;
                    end
                end
                default: begin
                    state_n_s = ST_SDX;
                    rd4_n_s   = 1'b0;
                    rd5_n_s   = 1'b1;
                end
            endcase
        end else begin
            state_n_s = state_r;
        end
    end

    // State and bank registers with synchronous reset.
    always_ff @(posedge phi2) begin
        if (rst) begin
            state_r     <= ST_SDX;
            mode_r      <= MD_8K;
            rd4_r       <= 1'b0;
            rd5_r       <= 1'b1;
            sdx_bank_r  <= {SDX_BANK_W{1'b1}};
            oss_bank_r  <= 2'd0;
`ifdef XEGS_EN
            xegs_bank_r <= {XB_W{1'b0}};
`endif
        end else begin
            state_r     <= state_n_s;
            mode_r      <= mode_n_s;
            rd4_r       <= rd4_n_s;
            rd5_r       <= rd5_n_s;
            sdx_bank_r  <= sdx_bank_n_s;
            oss_bank_r  <= oss_bank_n_s;
`ifdef XEGS_EN
            xegs_bank_r <= xegs_bank_n_s;
`endif
        end
    end

    assign s4_sel_s = rd4_r & ~s4_n & s5_n;
    assign s5_sel_s = rd5_r & ~s5_n & s4_n;
    assign sel_s    = s4_sel_s | s5_sel_s;
    // $B000 always shows the fixed top OSS bank.
    assign oss_lo_s = cart_a[12] ? {2'b11, cart_a[11:0]} : {oss_bank_r, cart_a[11:0]};

    // Flash address mapping for the active window.
    always_comb begin
        rom_a_s = {ROM_AW{1'b0}};
        case (state_r)
            ST_SDX: begin
                if (s5_sel_s) rom_a_s = ROM_AW'({sdx_bank_r, cart_a});
                else          rom_a_s = {ROM_AW{1'b0}};
            end
            ST_CART: begin
                case (mode_r)
                    MD_OSS043, MD_OSS034: begin
                        if (s5_sel_s) rom_a_s = ((mode_r == MD_OSS043) ? OSS043_OFS : OSS034_OFS)
                                                + ROM_AW'(oss_lo_s);
                        else          rom_a_s = {ROM_AW{1'b0}};
                    end
                    MD_16K: begin
                        if (s4_sel_s)      rom_a_s = CAR16_LO + ROM_AW'(cart_a);
                        else if (s5_sel_s) rom_a_s = CAR16_HI + ROM_AW'(cart_a);
                        else               rom_a_s = {ROM_AW{1'b0}};
                    end
`ifdef XEGS_EN
                    MD_XEGS: begin
                        if (s4_sel_s)      rom_a_s = XEGS_OFS + ROM_AW'({xegs_bank_r, 13'h0000})
                                                     + ROM_AW'(cart_a);
                        else if (s5_sel_s) rom_a_s = XEGS_LAST + ROM_AW'(cart_a);
                        else               rom_a_s = {ROM_AW{1'b0}};
                    end
`endif
                    default: begin
                        if (s5_sel_s) rom_a_s = CAR8_OFS + ROM_AW'(cart_a);
                        else          rom_a_s = {ROM_AW{1'b0}};
                    end
                endcase
            end
            default: rom_a_s = {ROM_AW{1'b0}};
        endcase
    end

    assign rd4       = rd4_r;
    assign rd5       = rd5_r;
    assign rom_a     = rom_a_s;
    assign rom_ce_n  = ~sel_s;
    assign rom_oe_n  = ~(sel_s & r_w);
    assign cart_d_oe = sel_s & r_w & phi2;
    assign led_sdx   = ~(state_r == ST_SDX);
    assign led_cart  = ~((state_r == ST_CART) &&
                         ((mode_r == MD_8K) || (mode_r == MD_16K) || (mode_r == MD_XEGS)));

endmodule

// File: tb/tb_cart_bank_ctrl.sv
// Self-checking bench for cart_bank_ctrl: directed scenarios plus random bus traffic against a behavioural model.
module tb_cart_bank_ctrl;

    localparam int ROM_AW     = 19;
    localparam int SDX_BANK_W = 4;
    localparam int XEGS_BANKS = 8;
`ifdef XEGS_EN
    localparam bit XEGS = 1'b1;
`else
    localparam bit XEGS = 1'b0;
`endif

    logic              phi2 = 1'b0;
    logic              rst = 1'b1;
    logic [12:0]       cart_a = 13'h0;
    logic [7:0]        cart_d_in = 8'h0;
    logic              s4_n = 1'b1, s5_n = 1'b1, cctl_n = 1'b1, r_w = 1'b1;
    logic [2:0]        cfg = 3'd0;
    logic              rd4, rd5, rom_ce_n, rom_oe_n, cart_d_oe, led_sdx, led_cart;
    logic [ROM_AW-1:0] rom_a;

    cart_bank_ctrl #(
        .ROM_AW(ROM_AW), .SDX_BANK_W(SDX_BANK_W), .OSS043_BASE(16), .OSS034_BASE(18),
        .CAR16_BASE(20), .CAR8_BASE(22), .XEGS_BASE(32), .XEGS_BANKS(XEGS_BANKS)
    ) dut (
        .phi2(phi2), .rst(rst), .cart_a(cart_a), .cart_d_in(cart_d_in), .s4_n(s4_n),
        .s5_n(s5_n), .cctl_n(cctl_n), .r_w(r_w), .cfg(cfg), .rd4(rd4), .rd5(rd5),
        .rom_a(rom_a), .rom_ce_n(rom_ce_n), .rom_oe_n(rom_oe_n), .cart_d_oe(cart_d_oe),
        .led_sdx(led_sdx), .led_cart(led_cart)
    );

    always #5 phi2 = ~phi2;

    int n_tests = 0;
    int n_fail  = 0;

    // model: state 0=SDX 1=CART 2=OFF; mode equals the cfg code (0 8K,1 16K,2 OSS034,3 OSS043,4 XEGS)
    int m_state, m_mode, m_sdx, m_oss, m_xegs;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int sdx_val(input int a);
        int v = 0;
        if (((a >> 4) & 1) == 0) v += 8;
        if (((a >> 2) & 1) == 0) v += 4;
        if (((a >> 1) & 1) == 0) v += 2;
        if ((a & 1) == 0)        v += 1;
        return v % (1 << SDX_BANK_W);
    endfunction

    task automatic model_reset();
        m_state = 0; m_mode = 0; m_sdx = (1 << SDX_BANK_W) - 1; m_oss = 0; m_xegs = 0;
    endtask

    task automatic model_write(input int a, input int d, input int c);
        bit win = (((a >> 5) & 7) == 7);
        int lo = a & 15;
        if (m_state == 0) begin
            if (win && lo < 8) m_sdx = sdx_val(a);
            else if (win && lo < 12) begin
                m_state = 1;
                m_mode  = (c <= 3) ? c : ((c == 4 && XEGS) ? 4 : 0);
            end else if (win) m_state = 2;
        end else if (m_state == 1) begin
            if (m_mode == 2 || m_mode == 3) begin
                if (lo >= 8)                m_state = 2;
                else if (lo == 0)           m_oss = 0;
                else if (lo == 3 || lo == 7) m_oss = (m_mode == 3) ? 2 : 1;
                else if (lo == 4)           m_oss = (m_mode == 3) ? 1 : 2;
                else                        m_oss = 3;
            end else if (win && lo >= 12) m_state = 2;
            else if (m_mode == 4)          m_xegs = d % XEGS_BANKS;
        end else if (win && lo < 8) begin
            m_state = 0; m_sdx = sdx_val(a); m_oss = 0; m_xegs = 0;
        end
    endtask

    function automatic bit m_rd4();
        return (m_state == 1) && (m_mode == 1 || m_mode == 4);
    endfunction

    function automatic bit m_rd5();
        return m_state != 2;
    endfunction

    function automatic int exp_rom(input int a, input bit s4n, input bit s5n);
        bit s4 = m_rd4() && !s4n && s5n;
        bit s5 = m_rd5() && !s5n && s4n;
        if (m_state == 0) return s5 ? m_sdx * 8192 + a : 0;
        if (m_state == 2) return 0;
        case (m_mode)
            2, 3:    return s5 ? ((m_mode == 3) ? 16 : 18) * 8192
                                 + ((a >= 4096) ? 3 : m_oss) * 4096 + (a % 4096) : 0;
            1:       return s4 ? 20 * 8192 + a : (s5 ? 21 * 8192 + a : 0);
            4:       return s4 ? (32 + m_xegs) * 8192 + a : (s5 ? (32 + XEGS_BANKS - 1) * 8192 + a : 0);
            default: return s5 ? 22 * 8192 + a : 0;
        endcase
    endfunction

    // {rd4, rd5, rom_ce_n, rom_oe_n, cart_d_oe, led_sdx, led_cart}
    function automatic logic [6:0] exp_ctl(input bit s4n, input bit s5n, input bit rw, input bit ph);
        bit sel = (m_rd4() && !s4n && s5n) || (m_rd5() && !s5n && s4n);
        bit lc  = (m_state == 1) && (m_mode == 0 || m_mode == 1 || m_mode == 4);
        return {m_rd4(), m_rd5(), !sel, !(sel && rw), sel && rw && ph, m_state != 0, !lc};
    endfunction

    task automatic compare_all(input string tag);
        check_eq({tag, "_rom"}, 32'(rom_a), 32'(exp_rom(int'(cart_a), s4_n, s5_n)));
        check_eq({tag, "_ctl"}, {25'd0, rd4, rd5, rom_ce_n, rom_oe_n, cart_d_oe, led_sdx, led_cart},
                 {25'd0, exp_ctl(s4_n, s5_n, r_w, phi2)});
    endtask

    // One bus cycle: drive on falling edge, check in both phases around the rising edge.
    task automatic run_cyc(input logic [12:0] a, input logic [7:0] d, input logic s4n, input logic s5n,
                           input logic cn, input logic rw, input logic [2:0] c, input logic r);
        @(negedge phi2);
        cart_a = a; cart_d_in = d; s4_n = s4n; s5_n = s5n; cctl_n = cn; r_w = rw; cfg = c; rst = r;
        #2;
        compare_all("lo");
        @(posedge phi2);
        if (r) model_reset();
        else if (!cn && !rw) model_write(int'(a), int'(d), int'(c));
        #2;
        compare_all("hi");
    endtask

    task automatic wr(input logic [12:0] a, input logic [7:0] d, input logic [2:0] c);
        run_cyc(a, d, 1'b1, 1'b1, 1'b0, 1'b0, c, 1'b0);
    endtask

    task automatic rd5_read(input logic [12:0] a);
        run_cyc(a, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, cfg, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge phi2);
        #2;
        check_eq("rst_state", {28'd0, rd4, rd5, led_sdx, led_cart}, 32'h5);

        // reset image read
        rd5_read(13'h0123);
        check_eq("t1_rom", 32'(rom_a), 32'h1E123);
        check_eq("t1_oe", 32'(cart_d_oe), 32'h1);
        // SDX bank select
        wr(13'h15E2, 8'h00, 3'd0);
        rd5_read(13'h0000);
        check_eq("t2_rom", 32'(rom_a), 32'h1A000);
        // OSS 043M banking then exit
        wr(13'h15E8, 8'h00, 3'd3);
        wr(13'h1503, 8'h00, 3'd3);
        rd5_read(13'h0010);
        rd5_read(13'h1010);
        wr(13'h1508, 8'h00, 3'd3);
        rd5_read(13'h0000);
        check_eq("t3_off", {30'd0, rd5, rom_ce_n}, 32'h1);
        // OFF back to SDX
        wr(13'h15E0, 8'h00, 3'd0);
        rd5_read(13'h0000);
        check_eq("t4_rom", 32'(rom_a), 32'h1E000);
        // cfg=4: XEGS if built, 8K otherwise
        wr(13'h15E8, 8'h00, 3'd4);
        wr(13'h1500, 8'h0B, 3'd4);
`ifdef XEGS_EN
        run_cyc(13'h0005, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd4, 1'b0);
        check_eq("t5_s4", 32'(rom_a), 32'h46005);
        rd5_read(13'h0005);
        check_eq("t5_s5", 32'(rom_a), 32'h4E005);
`else
        rd5_read(13'h0005);
        check_eq("t5_8k", 32'(rom_a), 32'h2C005);
`endif
        wr(13'h15EC, 8'h00, 3'd4);
        wr(13'h15E0, 8'h00, 3'd0);
        // 16K mapping, then reset during a mode-entry write
        wr(13'h15E8, 8'h00, 3'd1);
        run_cyc(13'h0777, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 3'd1, 1'b0);
        rd5_read(13'h1777);
        run_cyc(13'h15E8, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1);
        check_eq("t6_rst", {28'd0, rd4, rd5, led_sdx, led_cart}, 32'h5);
        run_cyc(13'h0000, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        check_eq("t6_both", 32'(cart_d_oe), 32'h0);

        // random traffic biased toward control-window writes
        for (int i = 0; i < 3000; i++) begin
            logic [12:0] a;
            a = 13'($urandom);
            if ($urandom_range(0, 1) == 0) a[7:5] = 3'b111;
            run_cyc(a, 8'($urandom), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) < 4) ? 1'b0 : 1'b1, 1'($urandom),
                    3'($urandom), ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
